down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable down-counter timer; the counting-down counterpart to the team's 4-bit enabled up-counter.
- Software/control logic loads a start value. The block decrements once per enabled clock and signals expiry with a one-cycle done pulse.
- Sits beside the up-counter in control paths that need timeouts or delays instead of event tallies.

Parameters:
- WIDTH, 4, bit width of count, load_value and the internal reload register.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_value and start or restart the countdown.
- load_value  input  WIDTH  start value, sampled when load=1.
- enable  input  1  decrement qualifier while running.
- stop  input  1  abort the countdown; return to IDLE without a done pulse.
- count  output  WIDTH  current remaining count (registered).
- busy  output  1  high while in RUN (registered).
- zero  output  1  high when count==0 (combinational from count).
- done  output  1  one-cycle expiry pulse (registered).

Behaviour:
- Reset: applied on the clk edge when reset=1, and overrides all other inputs. Values after reset:
  - count=0, busy=0, done=0, zero=1
  - reload register=0
  - state=IDLE
- States: IDLE and RUN. busy=1 exactly when the state is RUN.
- Input priority on every edge: reset > load > stop > enable.
- done defaults to 0 on every edge unless set by an expiry below.
- load=1 with load_value!=0, from any state:
  - count<=load_value, reload<=load_value, state<=RUN.
  - No done pulse, even if an expiry would have occurred that same cycle.
- load=1 with load_value==0: count<=0, state<=IDLE, done stays 0, reload is unchanged.
- stop=1 (and load=0) in RUN: state<=IDLE, count holds its current value, done=0.
- stop in IDLE has no effect.
- RUN, enable=1, count>1: count<=count-1.
- RUN, enable=1, count==1 (expiry):
  - done<=1 for exactly one cycle; done is high in the same cycle count first reads 0.
  - count<=0, state<=IDLE.
- RUN, enable=0: count holds and state stays RUN.
- IDLE: enable is ignored and count holds. There is never any underflow or wrap from 0 to all-ones.
- Latency: loading N and then holding enable=1 continuously gives done high on the Nth edge after the load edge, and busy high for N cycles.
- Arithmetic: unsigned WIDTH-bit; the maximum load is 2^WIDTH-1.

Optional Feature:
- Macro: DOWN_TIMER_AUTO_RELOAD_EN.
- Defined: on expiry (RUN, enable=1, count==1, no load or stop that cycle):
  - count<=reload, state stays RUN, busy stays 1, done pulses for one cycle.
  - This gives a periodic done every reload enabled cycles, until stop, load or reset.
  - Because of the value written on expiry, count never reads 0 while auto-reloading.
- Not defined: the expiry behaviour is exactly as in Behaviour (count<=0, return to IDLE), and the reload register may be optimised away.

Test Plan:
- Reset, then idle for 3 cycles -> count=0, zero=1, busy=0, done=0 throughout; enable=1 in IDLE leaves count at 0 (no wrap to 15).
- load_value=5, then enable=1 continuously -> count reads 4,3,2,1,0 on successive edges; done=1 only in the cycle count=0; busy falls the same cycle.
- load 6, enable toggled 1,0,1,0,... -> count decrements only on enabled edges; done arrives on the 12th edge after load.
- load 9, 3 enabled edges (count=6), then stop=1 with enable=1 -> count holds at 6, busy=0, no done. Then in a later cycle load=1 with stop=1 and load_value=2 -> load wins, count=2, busy=1.
- load 3, enable=1, with reset=1 asserted while count=1 -> next edge gives count=0, busy=0, done=0. Also: load=1 with load_value=0 -> no done, busy=0.
- With DOWN_TIMER_AUTO_RELOAD_EN, load 3 and enable=1 continuously -> count sequence 2,1,3,2,1,3...; done high on the edges where count reloads to 3, i.e. every 3 cycles; busy stays 1. Without the macro the same stimulus stops at 0 after a single done.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counter timer with a one-cycle done pulse on expiry.
// Optional build macro DOWN_TIMER_AUTO_RELOAD_EN: on expiry, reload the last
// loaded start value and keep running instead of returning to IDLE.
module down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // Next-state logic; priority is load > stop > enable (reset handled in the register).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            if (load_value != '0) begin
                count_d = load_value;
                state_d = StRun;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                reload_d = load_value;
`endif
            end else begin
                // A zero load is an immediate, silent return to IDLE.
                count_d = '0;
                state_d = StIdle;
            end
        end else if (stop) begin
            state_d = StIdle;
        end else if ((state_q == StRun) && enable) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = StIdle;
`endif
            end else begin
                // RUN with a zero count is unreachable; fall back to IDLE rather than wrap.
                state_d = StIdle;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // Reload register holds the most recent non-zero start value.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // Outputs: count/busy/done are registered, zero decodes the registered count.
    always_comb begin
        count = count_q;
        busy  = (state_q == StRun);
        zero  = (count_q == '0);
        done  = done_q;
    end

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: stimulus pushes expected post-edge outputs
// from a behavioural model; a monitor pops and compares on each falling edge.
module tb_down_timer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic         stop;
    logic [W-1:0] count;
    logic         busy;
    logic         zero;
    logic         done;

    down_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .stop       (stop),
        .count      (count),
        .busy       (busy),
        .zero       (zero),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit bsy;
        bit zr;
        bit dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state: remaining time, running flag, period memory.
    int m_remaining = 0;
    bit m_running   = 0;
    int m_period    = 0;
    bit m_done      = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(input bit r, input bit l, input int v,
                                       input bit e, input bit s);
        m_done = 0;
        if (r) begin
            m_remaining = 0;
            m_running   = 0;
            m_period    = 0;
        end else if (l) begin
            m_remaining = v;
            m_running   = (v != 0);
            if (v != 0) m_period = v;
        end else if (s) begin
            m_running = 0;
        end else if (m_running && e) begin
            m_remaining = m_remaining - 1;
            if (m_remaining == 0) begin
                m_done = 1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                m_remaining = m_period;
`else
                m_running = 0;
`endif
            end
        end
    endfunction

    // Drive one cycle of inputs, predict the outcome of the edge, hand it to the monitor.
    task automatic apply(input bit r, input bit l, input int v, input bit e, input bit s);
        exp_t x;
        reset      = r;
        load       = l;
        load_value = W'(v);
        enable     = e;
        stop       = s;
        @(posedge clk);
        model_step(r, l, v, e, s);
        x.cnt = m_remaining;
        x.bsy = m_running;
        x.zr  = (m_remaining == 0);
        x.dn  = m_done;
        exp_q.push_back(x);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check("count", int'(count), x.cnt);
            check("busy", int'(busy), int'(x.bsy));
            check("zero", int'(zero), int'(x.zr));
            check("done", int'(done), int'(x.dn));
        end
    end

    initial begin
        int first_done;
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; stop = 1'b0;

        // Reset, idle, and enable in IDLE must not wrap.
        apply(1, 0, 0, 0, 0);
        repeat (3) apply(0, 0, 0, 0, 0);
        repeat (3) apply(0, 0, 0, 1, 0);

        // Load 5, continuous enable.
        apply(0, 1, 5, 0, 0);
        repeat (7) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 1);

        // Load 6, enable toggled; first done expected on the 12th edge after load.
        apply(0, 1, 6, 1, 0);
        first_done = 0;
        for (int i = 1; i <= 20; i++) begin
            apply(0, 0, 0, (i % 2) == 0, 0);
            if (done && first_done == 0) first_done = i;
        end
        check("latency_toggled", first_done, 12);
        apply(0, 0, 0, 0, 1);

        // Load 9, three enabled edges, stop with enable, then load beats stop.
        apply(0, 1, 9, 0, 0);
        repeat (3) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 1, 1);
        repeat (2) apply(0, 0, 0, 1, 0);
        apply(0, 1, 2, 1, 1);
        repeat (3) apply(0, 0, 0, 1, 0);

        // Reset wins while count is 1; then a zero load.
        apply(0, 1, 3, 0, 0);
        repeat (2) apply(0, 0, 0, 1, 0);
        apply(1, 0, 0, 1, 0);
        apply(0, 1, 4, 0, 0);
        apply(0, 1, 0, 1, 0);
        apply(0, 0, 0, 1, 0);

        // Load on the expiry cycle suppresses done.
        apply(0, 1, 1, 0, 0);
        apply(0, 1, 7, 1, 0);
        apply(0, 0, 0, 1, 0);

        // Auto-reload candidate: load 3, long continuous enable; max load too.
        apply(0, 1, 3, 0, 0);
        repeat (10) apply(0, 0, 0, 1, 0);
        apply(0, 1, 15, 0, 0);
        repeat (18) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, l, e, s;
            int v;
            r = ($urandom_range(0, 79) == 0);
            l = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 24) == 0);
            e = ($urandom_range(0, 9) < 7);
            v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            apply(r, l, v, e, s);
        end

        apply(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
